cam_capture: RTL and testbench

CAM_CAPTURE -- requirements
Module: cam_capture

---
 rtl/cam_capture_pkg.sv | 26 ++
 rtl/cam_sync_edge.sv | 42 ++++
 rtl/cam_capture.sv | 181 ++++++++++++++++++
 tb/tb_cam_capture.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_capture_pkg.sv
// Shared video constants: default frame geometry (also used by the video timing
// controller), capture FSM state encoding, counter widths and the pixel payload.
package cam_capture_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  localparam int unsigned PIX_CNT_W  = 11;
  localparam int unsigned LINE_CNT_W = 10;
  localparam int unsigned PIX_W      = 12;
  localparam int unsigned BYTE_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_ACTIVE     = 2'd2
  } cap_state_e;

  // RGB444 pixel as written to the FIFO.
  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } pixel_t;

endpackage

// File: rtl/cam_sync_edge.sv
// Registers camera VSYNC/HREF and produces single-cycle edge pulses.
// Ports:
//   i_clk, i_rst          pixel clock, synchronous active-high reset
//   i_vsync, i_href       raw camera sync inputs
//   o_vsync_rise_c/fall_c combinational VSYNC edge pulses (current vs registered)
//   o_href_fall_c         combinational HREF falling-edge pulse
module cam_sync_edge
  import cam_capture_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_vsync,
  input  logic i_href,
  output logic o_vsync_rise_c,
  output logic o_vsync_fall_c,
  output logic o_href_fall_c
);

  logic vsync_q, vsync_d;
  logic href_q,  href_d;

  // History registers track the previous-cycle level.
  always_comb begin
    vsync_d = i_vsync;
    href_d  = i_href;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      vsync_q <= vsync_d;
      href_q  <= href_d;
    end
  end

  assign o_vsync_rise_c = i_vsync & ~vsync_q;
  assign o_vsync_fall_c = vsync_q & ~i_vsync;
  assign o_href_fall_c  = href_q & ~i_href;

endmodule

// File: rtl/cam_capture.sv
// Camera byte-stream capture: assembles RGB444 pixels from byte pairs during
// active lines and writes them to a FIFO, checking line/frame geometry.
// Ports:
//   i_clk, i_rst     pixel clock, synchronous active-high reset
//   i_cfg_done       camera configured (level); low forces IDLE
//   i_vsync, i_href  camera sync signals
//   i_data           camera byte bus
//   i_full           FIFO full
//   o_wr, o_wdata    FIFO write strobe and {red, green, blue} pixel
//   o_frame_done     one-cycle pulse at end of a captured frame
//   o_overflow       sticky: pixel dropped on FIFO full
//   o_line_err       sticky: line or frame length mismatch
module cam_capture
  import cam_capture_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cfg_done,
  input  logic              i_vsync,
  input  logic              i_href,
  input  logic [BYTE_W-1:0] i_data,
  output logic              o_wr,
  output logic [PIX_W-1:0]  o_wdata,
  input  logic              i_full,
  output logic              o_frame_done,
  output logic              o_overflow,
  output logic              o_line_err
);

  localparam logic [PIX_CNT_W-1:0]  H_TARGET = PIX_CNT_W'(H_ACTIVE);
  localparam logic [LINE_CNT_W-1:0] V_TARGET = LINE_CNT_W'(V_ACTIVE);
  localparam logic [PIX_CNT_W-1:0]  PIX_MAX  = '1;
  localparam logic [LINE_CNT_W-1:0] LINE_MAX = '1;

  cap_state_e            state_q, state_d;
  logic                  phase_q, phase_d;
  logic [3:0]            red_q, red_d;
  logic [PIX_CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic                  wr_q, wr_d;
  pixel_t                wdata_q, wdata_d;
  logic                  frame_done_q, frame_done_d;
  logic                  overflow_q, overflow_d;
  logic                  line_err_q, line_err_d;

  logic vsync_rise_c, vsync_fall_c, href_fall_c;

  cam_sync_edge u_sync_edge (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_vsync        (i_vsync),
    .i_href         (i_href),
    .o_vsync_rise_c (vsync_rise_c),
    .o_vsync_fall_c (vsync_fall_c),
    .o_href_fall_c  (href_fall_c)
  );

  // Next-state, pixel assembly and geometry checks.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    red_d        = red_q;
    pix_cnt_d    = pix_cnt_q;
    line_cnt_d   = line_cnt_q;
    wr_d         = 1'b0;
    wdata_d      = wdata_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    line_err_d   = line_err_q;

    if (!i_cfg_done) begin
      // Loss of configuration abandons everything in flight, no write issued.
      state_d    = ST_IDLE;
      phase_d    = 1'b0;
      pix_cnt_d  = '0;
      line_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT_FRAME;
        end

        ST_WAIT_FRAME: begin
          // Only a vsync fall starts capture, so a frame already underway is skipped.
          phase_d    = 1'b0;
          pix_cnt_d  = '0;
          line_cnt_d = '0;
          if (vsync_fall_c) begin
            state_d = ST_ACTIVE;
          end
        end

        ST_ACTIVE: begin
          if (i_href) begin
            if (!phase_q) begin
              red_d   = i_data[3:0];
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              // Dropped pixels still count toward line length.
              if (pix_cnt_q != PIX_MAX) begin
                pix_cnt_d = pix_cnt_q + 1'b1;
              end
              if (i_full) begin
                overflow_d = 1'b1;
              end else begin
                wr_d          = 1'b1;
                wdata_d.red   = red_q;
                wdata_d.green = i_data[7:4];
                wdata_d.blue  = i_data[3:0];
              end
            end
          end else begin
            // A trailing odd byte is discarded here.
            phase_d = 1'b0;
          end

          if (href_fall_c) begin
            if (pix_cnt_q != H_TARGET) begin
              line_err_d = 1'b1;
            end
            pix_cnt_d = '0;
            if (line_cnt_q != LINE_MAX) begin
              line_cnt_d = line_cnt_q + 1'b1;
            end
          end

          if (vsync_rise_c) begin
            if (line_cnt_q != V_TARGET) begin
              line_err_d = 1'b1;
            end
            line_cnt_d   = '0;
            frame_done_d = 1'b1;
            state_d      = ST_WAIT_FRAME;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      phase_q      <= 1'b0;
      red_q        <= '0;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      wr_q         <= 1'b0;
      wdata_q      <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      line_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      red_q        <= red_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      wr_q         <= wr_d;
      wdata_q      <= wdata_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      line_err_q   <= line_err_d;
    end
  end

  assign o_wr         = wr_q;
  assign o_wdata      = wdata_q;
  assign o_frame_done = frame_done_q;
  assign o_overflow   = overflow_q;
  assign o_line_err   = line_err_q;

endmodule

// File: tb/tb_cam_capture.sv
// Self-checking bench for cam_capture with a reduced frame geometry.
// Expected pixels are derived from each generated line's byte list and pushed
// to a queue; every FIFO write is checked against the queue in step().
module tb_cam_capture;

  localparam int unsigned H = 16;
  localparam int unsigned V = 8;

  logic        i_clk;
  logic        i_rst;
  logic        i_cfg_done;
  logic        i_vsync;
  logic        i_href;
  logic [7:0]  i_data;
  logic        i_full;
  logic        o_wr;
  logic [11:0] o_wdata;
  logic        o_frame_done;
  logic        o_overflow;
  logic        o_line_err;

  cam_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_cfg_done   (i_cfg_done),
    .i_vsync      (i_vsync),
    .i_href       (i_href),
    .i_data       (i_data),
    .o_wr         (o_wr),
    .o_wdata      (o_wdata),
    .i_full       (i_full),
    .o_frame_done (o_frame_done),
    .o_overflow   (o_overflow),
    .o_line_err   (o_line_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          wr_count = 0;
  logic [11:0] exp_q[$];
  logic [7:0]  line_buf [0:63];
  logic        full_buf [0:63];

  // One clock: drive inputs, let the DUT sample, check any write on the falling edge.
  task automatic step(input logic vs, input logic hr, input logic [7:0] d, input logic full);
    logic [11:0] exp_w;
    i_vsync = vs;
    i_href  = hr;
    i_data  = d;
    i_full  = full;
    @(posedge i_clk);
    @(negedge i_clk);
    if (o_wr === 1'b1) begin
      wr_count++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_wr: got o_wr=1 wdata=%h, required no write", o_wdata);
      end else begin
        exp_w = exp_q.pop_front();
        if (o_wdata !== exp_w) begin
          n_errors++;
          $display("FAIL wdata: got %h, required %h", o_wdata, exp_w);
        end
      end
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b0);
    i_rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic start_frame();
    repeat (3) step(1'b1, 1'b0, 8'h00, 1'b0);
    repeat (2) step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // Random bytes; optionally random FIFO-full on any byte.
  task automatic fill(input int n, input bit rand_full);
    for (int i = 0; i < n; i++) begin
      line_buf[i] = 8'($urandom);
      full_buf[i] = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  endtask

  // Model: pixel p = {byte[2p][3:0], byte[2p+1]}, dropped if full on its second byte.
  task automatic send_line(input int n, input bit expect_wr);
    if (expect_wr) begin
      for (int p = 0; p < n / 2; p++) begin
        if (!full_buf[2*p+1]) exp_q.push_back({line_buf[2*p][3:0], line_buf[2*p+1]});
      end
    end
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, line_buf[i], full_buf[i]);
    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_missing_wr: got %0d pixels unwritten, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    i_cfg_done = 1'b1;
    i_rst = 1'b1;
    step(1'b1, 1'b1, 8'hFF, 1'b1);
    i_rst = 1'b0;
    n_checks += 5;
    if (o_wr !== 1'b0)         begin n_errors++; $display("FAIL rst_wr: got %b, required 0", o_wr); end
    if (o_wdata !== 12'h000)   begin n_errors++; $display("FAIL rst_wdata: got %h, required 000", o_wdata); end
    if (o_frame_done !== 1'b0) begin n_errors++; $display("FAIL rst_frame_done: got %b, required 0", o_frame_done); end
    if (o_overflow !== 1'b0)   begin n_errors++; $display("FAIL rst_overflow: got %b, required 0", o_overflow); end
    if (o_line_err !== 1'b0)   begin n_errors++; $display("FAIL rst_line_err: got %b, required 0", o_line_err); end
  endtask

  task automatic test_full_frame();
    int w0;
    i_cfg_done = 1'b1;
    do_reset();
    step(1'b0, 1'b0, 8'h00, 1'b0);
    start_frame();
    w0 = wr_count;
    for (int l = 0; l < int'(V); l++) begin
      fill(2 * H, 1'b0);
      send_line(2 * H, 1'b1);
    end
    check_drained("frame");
    n_checks += 2;
    if (wr_count - w0 != int'(H * V)) begin n_errors++; $display("FAIL frame_wr_count: got %0d, required %0d", wr_count - w0, H * V); end
    if (o_frame_done !== 1'b0) begin n_errors++; $display("FAIL frame_done_early: got %b, required 0", o_frame_done); end
    step(1'b1, 1'b0, 8'h00, 1'b0);
    n_checks += 3;
    if (o_frame_done !== 1'b1) begin n_errors++; $display("FAIL frame_done: got %b, required 1", o_frame_done); end
    if (o_line_err !== 1'b0)   begin n_errors++; $display("FAIL frame_line_err: got %b, required 0", o_line_err); end
    if (o_overflow !== 1'b0)   begin n_errors++; $display("FAIL frame_overflow: got %b, required 0", o_overflow); end
    step(1'b1, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if (o_frame_done !== 1'b0) begin n_errors++; $display("FAIL frame_done_pulse: got %b, required 0", o_frame_done); end
  endtask

  task automatic test_pixel_format();
    do_reset();
    start_frame();
    step(1'b0, 1'b1, 8'h0A, 1'b0);
    n_checks++;
    if (o_wr !== 1'b0) begin n_errors++; $display("FAIL fmt_wr_phase0: got %b, required 0", o_wr); end
    exp_q.push_back(12'hA5C);
    step(1'b0, 1'b1, 8'h5C, 1'b0);
    n_checks += 2;
    if (o_wr !== 1'b1)       begin n_errors++; $display("FAIL fmt_wr: got %b, required 1", o_wr); end
    if (o_wdata !== 12'hA5C) begin n_errors++; $display("FAIL fmt_wdata: got %h, required a5c", o_wdata); end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    n_checks += 2;
    if (o_wr !== 1'b0)       begin n_errors++; $display("FAIL fmt_wr_single: got %b, required 0", o_wr); end
    if (o_line_err !== 1'b1) begin n_errors++; $display("FAIL fmt_short_line_err: got %b, required 1", o_line_err); end
    check_drained("fmt");
  endtask

  task automatic test_overflow();
    int w0;
    do_reset();
    start_frame();
    fill(2 * H, 1'b0);
    full_buf[7] = 1'b1;
    w0 = wr_count;
    send_line(2 * H, 1'b1);
    check_drained("ovf");
    n_checks += 3;
    if (wr_count - w0 != int'(H) - 1) begin n_errors++; $display("FAIL ovf_wr_count: got %0d, required %0d", wr_count - w0, H - 1); end
    if (o_overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_set: got %b, required 1", o_overflow); end
    if (o_line_err !== 1'b0) begin n_errors++; $display("FAIL ovf_line_err: got %b, required 0", o_line_err); end
    fill(2 * H, 1'b1);
    send_line(2 * H, 1'b1);
    check_drained("ovf_rand");
    n_checks++;
    if (o_overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky: got %b, required 1", o_overflow); end
  endtask

  task automatic test_odd_line();
    int w0;
    do_reset();
    start_frame();
    fill(2 * H - 1, 1'b0);
    w0 = wr_count;
    for (int i = 0; i < int'(H) - 1; i++) exp_q.push_back({line_buf[2*i][3:0], line_buf[2*i+1]});
    for (int i = 0; i < int'(2 * H) - 1; i++) step(1'b0, 1'b1, line_buf[i], 1'b0);
    n_checks++;
    if (o_line_err !== 1'b0) begin n_errors++; $display("FAIL odd_err_early: got %b, required 0", o_line_err); end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if (o_line_err !== 1'b1) begin n_errors++; $display("FAIL odd_line_err: got %b, required 1", o_line_err); end
    repeat (2) step(1'b0, 1'b0, 8'h00, 1'b0);
    check_drained("odd");
    n_checks++;
    if (wr_count - w0 != int'(H) - 1) begin n_errors++; $display("FAIL odd_wr_count: got %0d, required %0d", wr_count - w0, H - 1); end
  endtask

  task automatic test_short_frame();
    do_reset();
    start_frame();
    for (int l = 0; l < int'(V) - 1; l++) begin
      fill(2 * H, 1'b0);
      send_line(2 * H, 1'b1);
    end
    check_drained("short");
    n_checks++;
    if (o_line_err !== 1'b0) begin n_errors++; $display("FAIL short_err_early: got %b, required 0", o_line_err); end
    step(1'b1, 1'b0, 8'h00, 1'b0);
    n_checks += 2;
    if (o_line_err !== 1'b1)   begin n_errors++; $display("FAIL short_frame_err: got %b, required 1", o_line_err); end
    if (o_frame_done !== 1'b1) begin n_errors++; $display("FAIL short_frame_done: got %b, required 1", o_frame_done); end
  endtask

  task automatic test_midframe_cfg();
    int w0;
    i_cfg_done = 1'b0;
    do_reset();
    w0 = wr_count;
    fill(2 * H, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, line_buf[i], 1'b0);
    i_cfg_done = 1'b1;
    for (int i = 10; i < int'(2 * H); i++) step(1'b0, 1'b1, line_buf[i], 1'b0);
    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0);
    fill(2 * H, 1'b0);
    send_line(2 * H, 1'b0);
    n_checks++;
    if (wr_count != w0) begin n_errors++; $display("FAIL midcfg_no_wr: got %0d writes, required 0", wr_count - w0); end
    start_frame();
    fill(2 * H, 1'b0);
    send_line(2 * H, 1'b1);
    check_drained("midcfg");
    n_checks++;
    if (wr_count - w0 != int'(H)) begin n_errors++; $display("FAIL midcfg_wr: got %0d, required %0d", wr_count - w0, H); end
  endtask

  task automatic test_cfg_drop();
    int w0;
    do_reset();
    start_frame();
    w0 = wr_count;
    step(1'b0, 1'b1, 8'h12, 1'b0);
    i_cfg_done = 1'b0;
    step(1'b0, 1'b1, 8'h34, 1'b0);
    n_checks++;
    if (o_wr !== 1'b0) begin n_errors++; $display("FAIL cfgdrop_wr: got %b, required 0", o_wr); end
    i_cfg_done = 1'b1;
    fill(2 * H, 1'b0);
    send_line(2 * H, 1'b0);
    n_checks++;
    if (wr_count != w0) begin n_errors++; $display("FAIL cfgdrop_no_wr: got %0d writes, required 0", wr_count - w0); end
  endtask

  task automatic test_reset_midline();
    int w0;
    do_reset();
    start_frame();
    fill(2 * H, 1'b0);
    for (int p = 0; p < 3; p++) exp_q.push_back({line_buf[2*p][3:0], line_buf[2*p+1]});
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, line_buf[i], 1'b0);
    check_drained("rstmid_pre");
    i_rst = 1'b1;
    step(1'b0, 1'b1, line_buf[7], 1'b0);
    i_rst = 1'b0;
    n_checks += 5;
    if (o_wr !== 1'b0)         begin n_errors++; $display("FAIL rstmid_wr: got %b, required 0", o_wr); end
    if (o_wdata !== 12'h000)   begin n_errors++; $display("FAIL rstmid_wdata: got %h, required 000", o_wdata); end
    if (o_frame_done !== 1'b0) begin n_errors++; $display("FAIL rstmid_frame_done: got %b, required 0", o_frame_done); end
    if (o_overflow !== 1'b0)   begin n_errors++; $display("FAIL rstmid_overflow: got %b, required 0", o_overflow); end
    if (o_line_err !== 1'b0)   begin n_errors++; $display("FAIL rstmid_line_err: got %b, required 0", o_line_err); end
    w0 = wr_count;
    for (int i = 8; i < int'(2 * H); i++) step(1'b0, 1'b1, line_buf[i], 1'b0);
    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if (wr_count != w0) begin n_errors++; $display("FAIL rstmid_no_wr: got %0d writes, required 0", wr_count - w0); end
    start_frame();
    fill(2 * H, 1'b1);
    send_line(2 * H, 1'b1);
    check_drained("rstmid_post");
  endtask

  initial begin
    i_rst      = 1'b1;
    i_cfg_done = 1'b0;
    i_vsync    = 1'b0;
    i_href     = 1'b0;
    i_data     = 8'h00;
    i_full     = 1'b0;
    @(negedge i_clk);
    test_reset();
    test_full_frame();
    test_pixel_format();
    test_overflow();
    test_odd_line();
    test_short_frame();
    test_midframe_cfg();
    test_cfg_drop();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
